multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM that sequences a shared multicycle MIPS datapath
// (one memory port, one ALU, register file, IR and PC).
// Each instruction is stepped through fetch, decode, execute, memory and writeback states.
// Memory accesses hold their state until mem_ready completes the access.
//
// Optional feature: define ILLEGAL_TRAP_EN to trap unsupported opcode/funct codes.
//   - Defined: an unsupported code moves the FSM to HALT, where illegal_op=1 until reset.
//   - Undefined: an unsupported opcode acts as a NOP, an unsupported funct executes as add,
//     and illegal_op is tied to 0.
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   opcode, funct   IR[31:26] and IR[5:0]
//   zero            ALU zero flag, used for beq
//   mem_ready       memory completes the current access this cycle
//   mem_req         memory access request
//   mem_write       write qualifier for mem_req
//   i_or_d          memory address select (0=PC, 1=ALUOut)
//   ir_write        IR load enable
//   pc_write        PC load enable
//   pc_src          PC source select
//   alu_src_a       ALU operand A select
//   alu_src_b       ALU operand B select
//   alu_control     ALU operation select
//   reg_dst         register destination select
//   mem_to_reg      register write data select
//   reg_write       register file write enable
//   illegal_op      trap flag (tied 0 when ILLEGAL_TRAP_EN is undefined)
//   state_dbg       current state encoding
// Outputs are a Moore decode of the state register.
// ir_write and pc_write in FETCH also follow mem_ready, and pc_write in BRANCH follows zero.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [STATE_W-1:0] S_RST     = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECUTE = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDIEX  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_ADDIWB  = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JUMP    = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_HALT    = STATE_W'(13);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic [2:0]         funct_alu;
  logic               funct_ok;

  // R-type funct decode; unsupported codes fall back to add
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE: begin
`ifdef ILLEGAL_TRAP_EN
            next_state = funct_ok ? S_EXECUTE : S_HALT;
`else
            next_state = S_EXECUTE;
`endif
          end
          OP_BEQ:  next_state = S_BRANCH;
          OP_ADDI: next_state = S_ADDIEX;
          OP_J:    next_state = S_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            next_state = S_HALT;
`else
            next_state = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   if (mem_ready) next_state = S_FETCH;
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_RST;
    endcase
  end

  // Output decode; every output defaults to 0
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal_op  = 1'b0;
    state_dbg   = state;
    case (state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        // IR and PC load in the cycle the fetch completes
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = zero;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
`else
        illegal_op = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
// Each cycle, the expected state and output vector are queued as the inputs are driven.
// They are popped and compared on the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state_dbg;

  typedef struct {
    int          st;
    logic [16:0] outs;
    string       tag;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  logic [16:0] obs;
  assign obs = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected output vector for a state, written from the per-state output tables
  function automatic logic [16:0] exp_out(input int st, input logic [5:0] fn,
                                          input logic z, input logic mr);
    logic mreq, mw, iod, irw, pcw, asa, rd, m2r, rw, ill;
    logic [1:0] pcs, asb;
    logic [2:0] ac;
    {mreq, mw, iod, irw, pcw, asa, rd, m2r, rw, ill} = '0;
    pcs = 2'b00; asb = 2'b00; ac = 3'b000;
    case (st)
      1:  begin mreq = 1; asb = 2'b01; ac = 3'b010; irw = mr; pcw = mr; end
      2:  begin asb = 2'b11; ac = 3'b010; end
      3:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
      4:  begin mreq = 1; iod = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mreq = 1; mw = 1; iod = 1; end
      7: begin
        asa = 1;
        case (fn)
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      8:  begin rd = 1; rw = 1; end
      9:  begin asa = 1; ac = 3'b110; pcs = 2'b01; pcw = z; end
      10: begin asa = 1; asb = 2'b10; ac = 3'b010; end
      11: rw = 1;
      12: begin pcs = 2'b10; pcw = 1; end
      13: ill = 1;
      default: ;
    endcase
    return {mreq, mw, iod, irw, pcw, pcs, asa, asb, ac, rd, m2r, rw, ill};
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge
  task automatic cyc(input string tag, input int st, input logic mr, input logic z);
    exp_t e;
    mem_ready = mr;
    zero      = z;
    expq.push_back('{st, exp_out(st, funct, z, mr), tag});
    @(negedge clk);
    if (expq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = expq.pop_front();
      check({e.tag, "_state"}, 32'(state_dbg), 32'(e.st));
      check({e.tag, "_outs"}, 32'(obs), 32'(e.outs));
    end
    @(posedge clk); #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Unsupported code handling: trap to HALT (held until reset) or fall through
  task automatic illegal_path(input string tag, input logic is_rtype);
`ifdef ILLEGAL_TRAP_EN
    cyc(tag, 13, rb(), rb());
    cyc(tag, 13, rb(), rb());
    cyc(tag, 13, rb(), rb());
    reset = 1'b1;
    cyc({tag, "_rst"}, 13, rb(), rb());
    reset = 1'b0;
    cyc({tag, "_rst"}, 0, rb(), rb());
`else
    if (is_rtype) begin
      cyc(tag, 7, rb(), rb());
      cyc(tag, 8, rb(), rb());
    end
    check({tag, "_ill"}, 32'(illegal_op), 32'd0);
`endif
  endtask

  logic [5:0] fns [5] = '{6'b101010, 6'b100010, 6'b100000, 6'b100100, 6'b100101};

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    // Reset held, then released: RST then FETCH
    cyc("rst", 0, 1'b1, 1'b1);
    cyc("rst", 0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc("rst_rel", 0, 1'b1, 1'b1);

    // lw, no wait states: 1,2,3,4,5 then FETCH
    opcode = 6'b100011;
    cyc("lw", 1, 1'b1, rb());
    cyc("lw", 2, rb(), rb());
    cyc("lw", 3, rb(), rb());
    cyc("lw", 4, 1'b1, rb());
    cyc("lw", 5, rb(), rb());

    // sw with three wait cycles in MEMWR
    opcode = 6'b101011;
    cyc("sw", 1, 1'b1, rb());
    cyc("sw", 2, rb(), rb());
    cyc("sw", 3, rb(), rb());
    cyc("sw_wait", 6, 1'b0, rb());
    cyc("sw_wait", 6, 1'b0, rb());
    cyc("sw_wait", 6, 1'b0, rb());
    cyc("sw", 6, 1'b1, rb());

    // beq taken then not taken
    opcode = 6'b000100;
    cyc("beq1", 1, 1'b1, rb());
    cyc("beq1", 2, rb(), rb());
    cyc("beq1", 9, rb(), 1'b1);
    cyc("beq0", 1, 1'b1, rb());
    cyc("beq0", 2, rb(), rb());
    cyc("beq0", 9, rb(), 1'b0);

    // R-type over every supported funct, with one fetch wait cycle each
    opcode = 6'b000000;
    foreach (fns[i]) begin
      funct = fns[i];
      cyc("rtype", 1, 1'b0, rb());
      cyc("rtype", 1, 1'b1, rb());
      cyc("rtype", 2, rb(), rb());
      cyc("rtype", 7, rb(), rb());
      cyc("rtype", 8, rb(), rb());
    end

    // addi and j
    opcode = 6'b001000;
    cyc("addi", 1, 1'b1, rb());
    cyc("addi", 2, rb(), rb());
    cyc("addi", 10, rb(), rb());
    cyc("addi", 11, rb(), rb());
    opcode = 6'b000010;
    cyc("j", 1, 1'b1, rb());
    cyc("j", 2, rb(), rb());
    cyc("j", 12, rb(), rb());

    // Reset during a pending write: next edge drops to RST
    opcode = 6'b101011;
    cyc("swrst", 1, 1'b1, rb());
    cyc("swrst", 2, rb(), rb());
    cyc("swrst", 3, rb(), rb());
    reset = 1'b1;
    cyc("swrst", 6, 1'b0, rb());
    reset = 1'b0;
    cyc("swrst", 0, rb(), rb());

    // Reset during FETCH with mem_ready: load strobes still asserted
    reset = 1'b1;
    cyc("fetchrst", 1, 1'b1, rb());
    reset = 1'b0;
    cyc("fetchrst", 0, rb(), rb());

    // Unsupported funct
    opcode = 6'b000000; funct = 6'b000111;
    cyc("badfn", 1, 1'b1, rb());
    cyc("badfn", 2, rb(), rb());
    illegal_path("badfn", 1'b1);

    // Unsupported opcode
    opcode = 6'b111111;
    cyc("badop", 1, 1'b1, rb());
    cyc("badop", 2, rb(), rb());
    illegal_path("badop", 1'b0);
    cyc("badop_next", 1, 1'b0, rb());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
